pg_controller: RTL and testbench

//  Power-gating sequencer directly upstream of the CPU core; generates the core's activate and

---
 rtl/pg_controller.sv | 138 +++++++++++++
 tb/tb_pg_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pg_controller.sv
`default_nettype none
// ============================================================================
// Module      : pg_controller
// Description : Always-on power-gating sequencer for the CPU core. Walks
//               clock-gate -> isolate -> save -> power-off and the reverse,
//               with a bounded power-good wait on the way back up.
// Revision    : 1.0 - initial release
// ============================================================================
module pg_controller #(
    parameter int ISO_CYCLES    = 2,
    parameter int PWRUP_MIN     = 4,
    parameter int PWRUP_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       pwr_good,
    output logic       clk_en,
    output logic       isolate,
    output logic       activate,
    output logic       save,
    output logic       restore,
    output logic       sleep_ack,
    output logic       busy,
    output logic       pg_error,
    output logic [2:0] state_o
);

    localparam int c_cw = ($clog2(PWRUP_TIMEOUT + 1) > 5) ? $clog2(PWRUP_TIMEOUT + 1) : 5;

    localparam logic [c_cw-1:0] c_iso_last  = c_cw'(ISO_CYCLES - 1);
    localparam logic [c_cw-1:0] c_pu_min_m1 = c_cw'(PWRUP_MIN - 1);
    localparam logic [c_cw-1:0] c_pu_to_m1  = c_cw'(PWRUP_TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_cnt_max   = '1;

    localparam logic [2:0] c_st_on      = 3'd0;
    localparam logic [2:0] c_st_clkoff  = 3'd1;
    localparam logic [2:0] c_st_iso     = 3'd2;
    localparam logic [2:0] c_st_save    = 3'd3;
    localparam logic [2:0] c_st_off     = 3'd4;
    localparam logic [2:0] c_st_pwrup   = 3'd5;
    localparam logic [2:0] c_st_restore = 3'd6;
    localparam logic [2:0] c_st_deiso   = 3'd7;

    logic [2:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic            r_pg_error;
    logic [6:0]      r_outs;

    logic [2:0]      w_nxt_state;
    logic [c_cw-1:0] w_nxt_cnt;
    logic            w_nxt_err;

    // Output bundle: {clk_en, isolate, activate, save, restore, sleep_ack, busy}
    function automatic logic [6:0] f_decode(input logic [2:0] st);
        logic [6:0] v;
        v[6] = (st == c_st_on);
        v[5] = (st == c_st_iso) || (st == c_st_save) || (st == c_st_off) ||
               (st == c_st_pwrup) || (st == c_st_restore);
        v[4] = (st != c_st_off);
        v[3] = (st == c_st_save);
        v[2] = (st == c_st_restore);
        v[1] = (st == c_st_off);
        v[0] = (st != c_st_on) && (st != c_st_off);
        return v;
    endfunction

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_err   = r_pg_error;
        case (r_state)
            c_st_on: begin
                if (sleep_req) w_nxt_state = c_st_clkoff;
            end
            c_st_clkoff: begin
                w_nxt_state = c_st_iso;
                w_nxt_cnt   = '0;
            end
            c_st_iso: begin
                if (r_cnt == c_iso_last) w_nxt_state = c_st_save;
                else                     w_nxt_cnt   = r_cnt + 1'b1;
            end
            c_st_save: begin
                w_nxt_state = c_st_off;
            end
            c_st_off: begin
                if (wake_req) begin
                    w_nxt_state = c_st_pwrup;
                    w_nxt_cnt   = '0;
                end
            end
            c_st_pwrup: begin
                // pwr_good is only trusted once the rail has had PWRUP_MIN cycles
                if ((r_cnt >= c_pu_min_m1) && pwr_good) begin
                    w_nxt_state = c_st_restore;
                end else if (r_cnt == c_pu_to_m1) begin
                    w_nxt_state = c_st_off;
                    w_nxt_err   = 1'b1;
                end else if (r_cnt != c_cnt_max) begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            c_st_restore: begin
                w_nxt_state = c_st_deiso;
                w_nxt_cnt   = '0;
            end
            c_st_deiso: begin
                if (r_cnt == c_iso_last) w_nxt_state = c_st_on;
                else                     w_nxt_cnt   = r_cnt + 1'b1;
            end
            default: begin
                w_nxt_state = c_st_on;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_on;
            r_cnt      <= '0;
            r_pg_error <= 1'b0;
            r_outs     <= f_decode(c_st_on);
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_pg_error <= w_nxt_err;
            r_outs     <= f_decode(w_nxt_state);
        end
    end

    assign {clk_en, isolate, activate, save, restore, sleep_ack, busy} = r_outs;
    assign pg_error = r_pg_error;
    assign state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pg_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pg_controller
// Description : Randomized bench for pg_controller against a schedule-based
//               reference model of the power sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pg_controller;

    localparam int ISO_CYCLES    = 2;
    localparam int PWRUP_MIN     = 4;
    localparam int PWRUP_TIMEOUT = 16;
    localparam int N_CYCLES      = 4000;

    localparam int ON = 0, CLKOFF = 1, ISO = 2, SAVE = 3, OFF = 4, PWRUP = 5, RESTORE = 6, DEISO = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sleep_req = 1'b0;
    logic       wake_req = 1'b0;
    logic       pwr_good = 1'b0;
    logic       clk_en, isolate, activate, save, restore, sleep_ack, busy, pg_error;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of scheduled future states for fixed-length
    // phases, plus an elapsed-cycle count for the open-ended power-up wait.
    int m_state = ON;
    int m_q[$];
    int m_pu_n  = 0;
    bit m_err   = 1'b0;

    pg_controller #(
        .ISO_CYCLES   (ISO_CYCLES),
        .PWRUP_MIN    (PWRUP_MIN),
        .PWRUP_TIMEOUT(PWRUP_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sleep_req(sleep_req),
        .wake_req (wake_req),
        .pwr_good (pwr_good),
        .clk_en   (clk_en),
        .isolate  (isolate),
        .activate (activate),
        .save     (save),
        .restore  (restore),
        .sleep_ack(sleep_ack),
        .busy     (busy),
        .pg_error (pg_error),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = ON;
            m_q.delete();
            m_err = 1'b0;
        end else if (m_q.size() > 0) begin
            m_state = m_q.pop_front();
        end else begin
            case (m_state)
                ON: if (sleep_req) begin
                    m_state = CLKOFF;
                    for (int i = 0; i < ISO_CYCLES; i++) m_q.push_back(ISO);
                    m_q.push_back(SAVE);
                    m_q.push_back(OFF);
                end
                OFF: if (wake_req) begin
                    m_state = PWRUP;
                    m_pu_n  = 0;
                end
                PWRUP: begin
                    m_pu_n++;
                    if (m_pu_n >= PWRUP_MIN && pwr_good) begin
                        m_state = RESTORE;
                        for (int i = 0; i < ISO_CYCLES; i++) m_q.push_back(DEISO);
                        m_q.push_back(ON);
                    end else if (m_pu_n == PWRUP_TIMEOUT) begin
                        m_state = OFF;
                        m_err   = 1'b1;
                    end
                end
                default: m_state = ON;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("state_o",   32'(state_o),   32'(m_state));
        check("clk_en",    32'(clk_en),    32'(m_state == ON));
        check("isolate",   32'(isolate),   32'(m_state >= ISO && m_state <= RESTORE));
        check("activate",  32'(activate),  32'(m_state != OFF));
        check("save",      32'(save),      32'(m_state == SAVE));
        check("restore",   32'(restore),   32'(m_state == RESTORE));
        check("sleep_ack", 32'(sleep_ack), 32'(m_state == OFF));
        check("busy",      32'(busy),      32'(m_state != ON && m_state != OFF));
        check("pg_error",  32'(pg_error),  32'(m_err));
    endtask

    initial begin
        int pg_mode  = 0;
        int rst_hold = 2;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc % 48 == 0) pg_mode = $urandom_range(0, 2);
            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 179) == 0) rst_hold = $urandom_range(1, 2);
            end
            if ($urandom_range(0, 9) == 0) sleep_req = ~sleep_req;
            if ($urandom_range(0, 9) == 0) wake_req  = ~wake_req;
            case (pg_mode)
                0:       pwr_good = 1'b1;
                1:       pwr_good = 1'b0;
                default: pwr_good = ($urandom_range(0, 5) == 0);
            endcase
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
